digits_rom_arbiter: RTL and testbench

Round-robin arbiter that shares one 5x5 digit-bitmap ROM (`digits10_case`) between up to NREQ independent requesters, e.g. a score field, a timer field and a lives counter drawn on the same scanline. Each requester presents a digit/row address with a request. The arbiter grants one requester per cycle and returns the 5-bit row bitmap, tagged with the requester index, two cycles after the request is sampled. It sits between the `hvsync_generator`-driven pixel logic and the ROM, and replaces per-field ROM copies.

---
 rtl/digits_pkg.sv | 40 ++++
 rtl/digits10_case.sv | 41 ++++
 rtl/digits_rom_arbiter.sv | 126 ++++++++++++
 tb/tb_digits_rom_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/digits_pkg.sv
// Shared widths, digit-font limits and the round-robin pick helper for the digit ROM arbiter.
package digits_pkg;

  localparam int DIGIT_W   = 4;
  localparam int YOFS_W    = 3;
  localparam int ROW_W     = 5;
  localparam int DIGIT_MAX = 9;
  localparam int YOFS_MAX  = 4;
  localparam int RR_MAX    = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Scans downward so the last hit written is the one nearest to ptr.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req_mask,
                                       input logic [2:0]        ptr,
                                       input int                n);
    rr_pick_t res;
    int       cand;
    res.found = 1'b0;
    res.idx   = 3'd0;
    for (int k = RR_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        cand = (int'(ptr) + k) % n;
        if (req_mask[cand[2:0]]) begin
          res.found = 1'b1;
          res.idx   = cand[2:0];
        end else begin
          res.found = res.found;
        end
      end else begin
        res.found = res.found;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/digits10_case.sv
// 5x5 digit font ROM: one glyph row per digit/yofs, bit 4 is the leftmost pixel.
module digits10_case (
  input  logic [3:0] digit,
  input  logic [2:0] yofs,
  output logic [4:0] bits
);

  logic [24:0] glyph_s;

  // Glyph lookup; rows are packed top row first, unused codes are blank.
  always_comb begin
    glyph_s = 25'd0;
    case (digit)
      4'd0:    glyph_s = {5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b11111};
      4'd1:    glyph_s = {5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b11111};
      4'd2:    glyph_s = {5'b11111, 5'b00001, 5'b11111, 5'b10000, 5'b11111};
      4'd3:    glyph_s = {5'b11111, 5'b00001, 5'b11111, 5'b00001, 5'b11111};
      4'd4:    glyph_s = {5'b10001, 5'b10001, 5'b11111, 5'b00001, 5'b00001};
      4'd5:    glyph_s = {5'b11111, 5'b10000, 5'b11111, 5'b00001, 5'b11111};
      4'd6:    glyph_s = {5'b11111, 5'b10000, 5'b11111, 5'b10001, 5'b11111};
      4'd7:    glyph_s = {5'b11111, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
      4'd8:    glyph_s = {5'b11111, 5'b10001, 5'b11111, 5'b10001, 5'b11111};
      4'd9:    glyph_s = {5'b11111, 5'b10001, 5'b11111, 5'b00001, 5'b11111};
      default: glyph_s = 25'd0;
    endcase
  end

  // Row select within the glyph.
  always_comb begin
    bits = 5'd0;
    case (yofs)
      3'd0:    bits = glyph_s[24:20];
      3'd1:    bits = glyph_s[19:15];
      3'd2:    bits = glyph_s[14:10];
      3'd3:    bits = glyph_s[9:5];
      3'd4:    bits = glyph_s[4:0];
      default: bits = 5'd0;
    endcase
  end

endmodule

// File: rtl/digits_rom_arbiter.sv
// Round-robin arbiter sharing one digits10_case ROM between NREQ requesters, 2-cycle latency.
// Optional range checking (rsp_err port) is enabled by defining DIGITS_ARB_RANGE_CHECK_EN.
module digits_rom_arbiter
  import digits_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [DIGIT_W*NREQ-1:0] req_digit,
  input  logic [YOFS_W*NREQ-1:0]  req_yofs,
  output logic [NREQ-1:0]         gnt,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [ROW_W-1:0]        rsp_bits
`ifdef DIGITS_ARB_RANGE_CHECK_EN
  , output logic                  rsp_err
`endif
);

  logic [RR_MAX-1:0]  mask_s;
  rr_pick_t           pick_s;
  logic [NREQ-1:0]    gnt_next_s;
  logic [IDW-1:0]     ptr_next_s;
  logic [DIGIT_W-1:0] sel_digit_s;
  logic [YOFS_W-1:0]  sel_yofs_s;
  logic [ROW_W-1:0]   rom_bits_s;

  logic [IDW-1:0]     ptr_r;
  logic               s1_valid_r;
  logic [IDW-1:0]     s1_id_r;
  logic [DIGIT_W-1:0] s1_digit_r;
  logic [YOFS_W-1:0]  s1_yofs_r;

  // Arbitration: a requester granted this cycle is masked so a lingering req is not reissued.
  always_comb begin
    mask_s = {RR_MAX{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      mask_s[i] = req[i] & ~gnt[i];
    end
    pick_s = rr_pick(mask_s, 3'(ptr_r), NREQ);
    for (int i = 0; i < NREQ; i++) begin
      gnt_next_s[i] = pick_s.found && (pick_s.idx == 3'(i));
    end
    if (int'(pick_s.idx) == NREQ - 1) begin
      ptr_next_s = {IDW{1'b0}};
    end else begin
      ptr_next_s = IDW'(pick_s.idx) + IDW'(1);
    end
    sel_digit_s = req_digit[int'(pick_s.idx)*DIGIT_W +: DIGIT_W];
    sel_yofs_s  = req_yofs[int'(pick_s.idx)*YOFS_W +: YOFS_W];
  end

  // Stage 1: register the grant and latch the winner's address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r      <= {IDW{1'b0}};
      gnt        <= {NREQ{1'b0}};
      s1_valid_r <= 1'b0;
      s1_id_r    <= {IDW{1'b0}};
      s1_digit_r <= {DIGIT_W{1'b0}};
      s1_yofs_r  <= {YOFS_W{1'b0}};
    end else if (pick_s.found) begin
      ptr_r      <= ptr_next_s;
      gnt        <= gnt_next_s;
      s1_valid_r <= 1'b1;
      s1_id_r    <= IDW'(pick_s.idx);
      s1_digit_r <= sel_digit_s;
      s1_yofs_r  <= sel_yofs_s;
    end else begin
      gnt        <= {NREQ{1'b0}};
      s1_valid_r <= 1'b0;
    end
  end

  digits10_case u_rom (
    .digit (s1_digit_r),
    .yofs  (s1_yofs_r),
    .bits  (rom_bits_s)
  );

`ifdef DIGITS_ARB_RANGE_CHECK_EN
  logic range_bad_s;

  // Out-of-font addresses are flagged rather than trusted to the ROM's blank codes.
  always_comb begin
    range_bad_s = (s1_digit_r > DIGIT_W'(DIGIT_MAX)) || (s1_yofs_r > YOFS_W'(YOFS_MAX));
  end

  // Stage 2: response registers with range flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= {IDW{1'b0}};
      rsp_bits  <= {ROW_W{1'b0}};
      rsp_err   <= 1'b0;
    end else if (s1_valid_r) begin
      rsp_valid <= 1'b1;
      rsp_id    <= s1_id_r;
      rsp_bits  <= range_bad_s ? {ROW_W{1'b0}} : rom_bits_s;
      rsp_err   <= range_bad_s;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end
  end
`else
  // Stage 2: response registers; idle cycles keep the last id and bitmap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= {IDW{1'b0}};
      rsp_bits  <= {ROW_W{1'b0}};
    end else if (s1_valid_r) begin
      rsp_valid <= 1'b1;
      rsp_id    <= s1_id_r;
      rsp_bits  <= rom_bits_s;
    end else begin
      rsp_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_digits_rom_arbiter.sv
// Scoreboard bench for digits_rom_arbiter: directed scenarios plus randomized traffic.
module tb_digits_rom_arbiter;

  localparam int N = 4;

  typedef struct {
    int         id;
    logic [4:0] bits;
    logic       err;
    int         due;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_digit;
  logic [11:0] req_yofs;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [4:0]  rsp_bits;
`ifdef DIGITS_ARB_RANGE_CHECK_EN
  logic        rsp_err;
`else
  logic        rsp_err = 1'b0;
`endif

  digits_rom_arbiter #(.NREQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_digit (req_digit),
    .req_yofs  (req_yofs),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_bits  (rsp_bits)
`ifdef DIGITS_ARB_RANGE_CHECK_EN
    , .rsp_err (rsp_err)
`endif
  );

  always #5 clk = ~clk;

  logic [4:0] font [10][5];
  logic [3:0] gq [$];
  rsp_t       rq [$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         edge_n  = 0;
  int         m_ptr   = 0;
  int         m_gnt   = -1;

  // Monitor: compares every cycle just after the clock edge.
  initial begin
    logic [3:0] eg;
    rsp_t       er;
    forever begin
      @(posedge clk);
      #1;
      edge_n++;
      if (!reset) begin
        n_tests++;
        if (gnt !== 4'd0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_bits !== 5'd0 || rsp_err !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_zero: gnt=%b valid=%b id=%0d bits=%b err=%b, required all 0", gnt, rsp_valid, rsp_id, rsp_bits, rsp_err);
        end
      end else begin
        if (gq.size() > 0) begin
          eg = gq.pop_front();
          n_tests++;
          if (gnt !== eg) begin
            n_fail++;
            $display("FAIL gnt: got %b, required %b (edge %0d)", gnt, eg, edge_n);
          end
        end
        if (rsp_valid === 1'b1) begin
          n_tests++;
          if (rq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rsp: got valid id=%0d bits=%b, required no response", rsp_id, rsp_bits);
          end else begin
            er = rq.pop_front();
            if (rsp_id !== 2'(er.id) || rsp_bits !== er.bits || rsp_err !== er.err || edge_n != er.due) begin
              n_fail++;
              $display("FAIL rsp: got id=%0d bits=%b err=%b edge=%0d, required id=%0d bits=%b err=%b edge=%0d",
                       rsp_id, rsp_bits, rsp_err, edge_n, er.id, er.bits, er.err, er.due);
            end
          end
        end else if (rq.size() > 0 && rq[0].due <= edge_n) begin
          er = rq.pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL missing_rsp: got valid=%b, required id=%0d bits=%b at edge %0d", rsp_valid, er.id, er.bits, er.due);
        end
      end
    end
  end

  // One cycle of stimulus; the reference model predicts grant and response.
  task automatic step(input logic [3:0] r, input logic [15:0] d, input logic [11:0] y);
    int   win;
    int   dg;
    int   yo;
    rsp_t e;
    req = r; req_digit = d; req_yofs = y;
    win = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (win < 0 && r[i] && m_gnt != i) win = i;
    end
    if (win >= 0) begin
      dg = int'(d[4*win +: 4]);
      yo = int'(y[3*win +: 3]);
      gq.push_back(4'(1 << win));
      e.id  = win;
      e.due = edge_n + 2;
      if (dg <= 9 && yo <= 4) begin
        e.bits = font[dg][yo];
        e.err  = 1'b0;
      end else begin
        e.bits = 5'd0;
`ifdef DIGITS_ARB_RANGE_CHECK_EN
        e.err  = 1'b1;
`else
        e.err  = 1'b0;
`endif
      end
      rq.push_back(e);
      m_ptr = (win + 1) % N;
      m_gnt = win;
    end else begin
      gq.push_back(4'd0);
      m_gnt = -1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, 16'd0, 12'd0);
  endtask

  task automatic reset_dut(input int hold);
    reset = 1'b0;
    gq.delete();
    rq.delete();
    m_ptr = 0;
    m_gnt = -1;
    req = 4'd0;
    repeat (hold) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [24:0] g [10];
    g[0] = {5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b11111};
    g[1] = {5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b11111};
    g[2] = {5'b11111, 5'b00001, 5'b11111, 5'b10000, 5'b11111};
    g[3] = {5'b11111, 5'b00001, 5'b11111, 5'b00001, 5'b11111};
    g[4] = {5'b10001, 5'b10001, 5'b11111, 5'b00001, 5'b00001};
    g[5] = {5'b11111, 5'b10000, 5'b11111, 5'b00001, 5'b11111};
    g[6] = {5'b11111, 5'b10000, 5'b11111, 5'b10001, 5'b11111};
    g[7] = {5'b11111, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
    g[8] = {5'b11111, 5'b10001, 5'b11111, 5'b10001, 5'b11111};
    g[9] = {5'b11111, 5'b10001, 5'b11111, 5'b00001, 5'b11111};
    for (int dd = 0; dd < 10; dd++)
      for (int rr = 0; rr < 5; rr++)
        font[dd][rr] = g[dd][24 - 5*rr -: 5];

    reset = 1'b0; req = 4'd0; req_digit = 16'd0; req_yofs = 12'd0;
    @(negedge clk);
    reset_dut(2);

    // single request: digit 1 row 0
    step(4'b0001, 16'h0001, 12'o0000);
    idle(3);

    // all four simultaneous from ptr 0: digits 0/2/8/9 at row 2
    reset_dut(1);
    repeat (5) step(4'b1111, 16'h9820, 12'o2222);
    idle(3);

    // requester 2 holds req alone
    repeat (6) step(4'b0100, 16'h0700, 12'o0100);
    idle(3);

    // fairness after requester 3 wins
    step(4'b1000, 16'h5000, 12'o4000);
    step(4'b1001, 16'h5003, 12'o4001);
    step(4'b1001, 16'h5003, 12'o4001);
    idle(3);

    // reset while gnt = 0100, then ptr must restart at 0
    step(4'b0010, 16'h0040, 12'o0010);
    step(4'b0100, 16'h0600, 12'o0300);
    reset_dut(2);
    idle(3);
    repeat (2) step(4'b1111, 16'h4321, 12'o1234);
    idle(3);

    // out-of-range address: digit 12, row 3
    step(4'b0010, 16'h00C0, 12'o0030);
    idle(3);

    // randomized traffic with occasional reset
    for (int t = 0; t < 500; t++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_dut(1);
      end else begin
        step(4'($urandom), 16'($urandom), 12'($urandom));
      end
    end
    idle(4);

    n_tests++;
    if (rq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", rq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
